led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Consumer end of the processor's 144-bit `led_commands` bus.
- Turns nine LEDs × two colour channels × 8-bit duty values into 18 PWM-modulated `led_pins`.
- Sits between the processor core and the board LED pins.
- Double-buffers commands with a valid/ready handshake, so new duty values only take effect on a PWM period boundary and never glitch mid-period.

Parameters:
- NUM_CH, 18, number of PWM channels/pins (9 LEDs × 2 colours).
- DUTY_W, 8, duty-cycle width per channel; the PWM period is 2^DUTY_W steps.
- PRESCALE, 196, clocks per PWM step (≈1 kHz frame at 50 MHz); legal range ≥1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- led_commands  input  NUM_CH*DUTY_W (144)  duty values; channel k = bits [DUTY_W*k+DUTY_W-1 : DUTY_W*k].
- cmd_valid  input  1  `led_commands` holds a new frame to accept.
- cmd_ready  output  1  shadow buffer empty; a command is accepted when valid && ready.
- led_pins  output  NUM_CH  PWM outputs; bit k is driven by channel k.
- frame_start  output  1  one-clock pulse when a shadow frame is committed to the active set.

Behaviour:
- **Interface:** one clock (`clock`); reset (`reset`) is asynchronous and active-low.
- **Reset values (immediate, asynchronous, also mid-operation):**
  - led_pins=0, frame_start=0, cmd_ready=1.
  - Internal: pending=0, shadow=0, active=0, presc_cnt=0, pwm_cnt=0.
- **Prescaler:**
  - presc_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle where presc_cnt==PRESCALE-1.
  - With PRESCALE=1, tick is 1 every cycle.
- **PWM counter:** pwm_cnt (DUTY_W bits) increments on tick and wraps 2^DUTY_W-1 → 0.
- **Boundary:** boundary = tick && pwm_cnt==2^DUTY_W-1, i.e. the cycle in which pwm_cnt wraps to 0.
- **Handshake:**
  - cmd_ready = ~pending, driven directly from a register (no combinational path from cmd_valid).
  - On cmd_valid && cmd_ready: shadow <= led_commands, pending <= 1.
  - cmd_valid while ready=0 is ignored; the source must hold the data.
- **Commit:**
  - On boundary with pending=1: active <= shadow, pending <= 0, frame_start <= 1 next cycle (one-cycle pulse).
  - On boundary with pending=0: no change, no pulse.
- **Simultaneous accept and boundary:**
  - A command accepted in a boundary cycle (pending was 0) goes into shadow only.
  - It commits at the next boundary, never the same cycle.
  - Accept and commit cannot collide, because accept requires pending=0 and commit requires pending=1.
- **Pin compare:**
  - led_pins[k] is registered: led_pins[k] <= (pwm_cnt < active[k]), unsigned.
  - One clock latency from a pwm_cnt/active change to the pin.
  - Duty 0: pin always 0.
  - Duty 2^DUTY_W-1: high for 255/256 steps (never fully on).
  - Duty d: high for exactly d×PRESCALE clocks per period of 2^DUTY_W×PRESCALE clocks.
- **Mid-period command:** shadow changes but the pins keep the old active duty until the next boundary; no partial-period glitch.
- **Mid-operation reset:** all state and pins clear at once. After release, counting restarts from 0 and the first period is full length.

Test Plan (PRESCALE=2, DUTY_W=8 for simulation; period = 512 clocks):
- Reset release, no commands:
  - led_pins=0 for 2000 clocks.
  - cmd_ready=1 throughout; frame_start never pulses.
- Send channel 0 = 128, channel 17 = 255, rest 0, one-cycle valid:
  - cmd_ready drops next cycle.
  - frame_start pulses at the first boundary.
  - Following period: pin0 high 256 clocks / low 256; pin17 high 510 / low 2; others 0.
  - cmd_ready returns to 1 after the commit.
- Send 0x40 on channel 3 mid-period, then assert valid again with 0x80 while ready=0:
  - The second command is not accepted.
  - The next full period shows pin3 high 128 clocks.
  - After ready rises, the held 0x80 is accepted; the period after its commit shows 256 high clocks.
- Assert valid exactly in a boundary cycle with pending=0:
  - Accepted into shadow; no frame_start that cycle.
  - Commit and frame_start occur one full period (512 clocks) later.
- All channels 0xFF, then assert reset low mid-period:
  - led_pins=0x00000 immediately (asynchronous, same cycle); cmd_ready=1.
  - After release, pins stay 0 until a new command commits.
- PRESCALE=1 build, channel 5 = 1:
  - pin5 is high exactly 1 clock per 256-clock period.
  - The rising edge occurs one clock after pwm_cnt wraps to 0.

Source files
------------

// File: rtl/led_pwm_driver_if.sv
// Command channel into the LED PWM driver: one full duty frame per valid/ready transfer.
// Channel k occupies bits [DUTY_W*k +: DUTY_W] of led_commands.
interface led_pwm_driver_if #(
    parameter int NUM_CH = 18,
    parameter int DUTY_W = 8
);
    logic [NUM_CH*DUTY_W-1:0] led_commands;
    logic                     cmd_valid;
    logic                     cmd_ready;

    modport master (
        output led_commands,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  led_commands,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/led_pwm_driver.sv
// Double-buffered PWM driver for nine bi-colour LEDs (18 pins).
// New duty frames land in a shadow buffer and are committed only when the PWM counter wraps.
module led_pwm_driver #(
    parameter int NUM_CH   = 18,
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 196
) (
    input  logic              clock,
    input  logic              reset,
    led_pwm_driver_if.slave   cmd_if,
    output logic [NUM_CH-1:0] led_pins,
    output logic              frame_start
);

    localparam int                  PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0]   PWM_LAST   = {DUTY_W{1'b1}};
    localparam int                  FRAME_W    = NUM_CH * DUTY_W;

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [DUTY_W-1:0]  pwm_cnt_q,   pwm_cnt_d;
    logic               pending_q,   pending_d;
    logic [FRAME_W-1:0] shadow_q,    shadow_d;
    logic [FRAME_W-1:0] active_q,    active_d;
    logic [NUM_CH-1:0]  led_pins_q,  led_pins_d;
    logic               frame_start_q, frame_start_d;

    logic tick;
    logic boundary;
    logic accept;
    logic commit;

    assign tick     = (presc_cnt_q == PRESC_LAST);
    assign boundary = tick && (pwm_cnt_q == PWM_LAST);
    // Accept needs pending=0 and commit needs pending=1, so they never coincide.
    assign accept   = cmd_if.cmd_valid && !pending_q;
    assign commit   = boundary && pending_q;

    // NOTE: every _d signal gets a default before any branch so no latch is inferred.
    always_comb begin
        presc_cnt_d   = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d     = pwm_cnt_q;
        pending_d     = pending_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        frame_start_d = commit;
        led_pins_d    = '0;

        if (tick) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = pwm_cnt_q + DUTY_W'(1);
        end

        if (accept) begin
            shadow_d  = cmd_if.led_commands;
            pending_d = 1'b1;
        end else if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // Compare against the current count so pins trail pwm_cnt/active by one clock.
        for (int k = 0; k < NUM_CH; k++) begin
            led_pins_d[k] = (pwm_cnt_q < active_q[k*DUTY_W +: DUTY_W]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_cnt_q   <= '0;
            pwm_cnt_q     <= '0;
            pending_q     <= 1'b0;
            // NOTE: the frame buffers are plain flops, so they reset too and the LEDs come up dark.
            shadow_q      <= '0;
            active_q      <= '0;
            led_pins_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_cnt_q   <= presc_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            led_pins_q    <= led_pins_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cmd_if.cmd_ready = ~pending_q;
    assign led_pins         = led_pins_q;
    assign frame_start      = frame_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver: stimulus queues per-channel high-clock counts,
// a monitor measures each committed period and compares.
module tb_led_pwm_driver;

    localparam int NUM_CH = 18;
    localparam int DUTY_W = 8;
    localparam int PERIOD = 512;

    typedef logic [NUM_CH-1:0][9:0] exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    led_pwm_driver_if #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W)) bus_a ();
    led_pwm_driver_if #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W)) bus_b ();

    logic [NUM_CH-1:0] pins_a, pins_b;
    logic              fs_a, fs_b;

    led_pwm_driver #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESCALE(2)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .cmd_if      (bus_a),
        .led_pins    (pins_a),
        .frame_start (fs_a)
    );

    led_pwm_driver #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESCALE(1)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .cmd_if      (bus_b),
        .led_pins    (pins_b),
        .frame_start (fs_b)
    );

    initial forever #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   frames_checked = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: on every frame_start pop the expected counts and measure the next full period.
    bit   mon_counting = 1'b0;
    int   mon_n = 0;
    int   mon_hi[NUM_CH];
    exp_t mon_cur;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_counting = 1'b0;
                continue;
            end
            if (mon_counting) begin
                for (int k = 0; k < NUM_CH; k++) mon_hi[k] += int'(pins_a[k]);
                mon_n++;
                if (mon_n == PERIOD) begin
                    for (int k = 0; k < NUM_CH; k++)
                        check($sformatf("duty_ch%0d", k), 64'(mon_hi[k]), 64'(mon_cur[k]));
                    mon_counting = 1'b0;
                    frames_checked++;
                end
            end
            if (fs_a) begin
                check("frame_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_cur      = sb_q.pop_front();
                    mon_counting = 1'b1;
                    mon_n        = 0;
                    for (int k = 0; k < NUM_CH; k++) mon_hi[k] = 0;
                end
            end
        end
    end

    task automatic wait_fs(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!fs_a && n < bound);
        check("fs_within_bound", 64'(fs_a), 64'd1);
    endtask

    logic [NUM_CH*DUTY_W-1:0] cmd;
    exp_t e;
    int   n;
    int   bad_pins, bad_rdy, bad_fs;
    int   b_high, b_first, b_second, b_other;

    initial begin
        bus_a.cmd_valid = 1'b0;
        bus_a.led_commands = '0;
        bus_b.cmd_valid = 1'b0;
        bus_b.led_commands = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pins", 64'(pins_a), 64'd0);
        check("rst_ready", 64'(bus_a.cmd_ready), 64'd1);
        check("rst_fs", 64'(fs_a), 64'd0);
        reset = 1'b1;

        // Idle: nothing commanded, nothing should move on the outputs.
        bad_pins = 0; bad_rdy = 0; bad_fs = 0;
        repeat (2000) begin
            @(negedge clock);
            if (pins_a != '0 || pins_b != '0) bad_pins++;
            if (!bus_a.cmd_ready || !bus_b.cmd_ready) bad_rdy++;
            if (fs_a || fs_b) bad_fs++;
        end
        check("idle_pins_zero", 64'(bad_pins), 64'd0);
        check("idle_ready_high", 64'(bad_rdy), 64'd0);
        check("idle_no_fs", 64'(bad_fs), 64'd0);

        // ch0=128 -> 256 clocks, ch17=255 -> 510 clocks.
        cmd = '0;
        cmd[0*DUTY_W +: DUTY_W]  = 8'd128;
        cmd[17*DUTY_W +: DUTY_W] = 8'd255;
        e = '0; e[0] = 10'd256; e[17] = 10'd510;
        sb_q.push_back(e);
        bus_a.led_commands = cmd;
        bus_a.cmd_valid = 1'b1;
        @(negedge clock);
        bus_a.cmd_valid = 1'b0;
        check("ready_drop", 64'(bus_a.cmd_ready), 64'd0);
        wait_fs(600, n);
        check("ready_after_commit", 64'(bus_a.cmd_ready), 64'd1);

        // Mid-period 0x40 on ch3, then 0x80 held while ready is low.
        repeat (100) @(negedge clock);
        cmd = '0;
        cmd[3*DUTY_W +: DUTY_W] = 8'h40;
        e = '0; e[3] = 10'd128;
        sb_q.push_back(e);
        bus_a.led_commands = cmd;
        bus_a.cmd_valid = 1'b1;
        @(negedge clock);
        check("ready_drop_mid", 64'(bus_a.cmd_ready), 64'd0);
        cmd[3*DUTY_W +: DUTY_W] = 8'h80;
        e = '0; e[3] = 10'd256;
        sb_q.push_back(e);
        bus_a.led_commands = cmd;
        repeat (50) @(negedge clock);
        check("held_not_accepted", 64'(bus_a.cmd_ready), 64'd0);
        wait_fs(600, n);
        check("ready_rises", 64'(bus_a.cmd_ready), 64'd1);
        @(negedge clock);
        bus_a.cmd_valid = 1'b0;
        check("held_accepted", 64'(bus_a.cmd_ready), 64'd0);
        wait_fs(600, n);

        // Valid exactly in the boundary cycle one period after that commit.
        repeat (PERIOD - 1) @(negedge clock);
        cmd = '0;
        cmd[1*DUTY_W +: DUTY_W] = 8'h10;
        cmd[2*DUTY_W +: DUTY_W] = 8'h01;
        e = '0; e[1] = 10'd32; e[2] = 10'd2;
        sb_q.push_back(e);
        bus_a.led_commands = cmd;
        bus_a.cmd_valid = 1'b1;
        @(negedge clock);
        bus_a.cmd_valid = 1'b0;
        check("boundary_no_fs", 64'(fs_a), 64'd0);
        check("boundary_accept", 64'(bus_a.cmd_ready), 64'd0);
        wait_fs(600, n);
        check("boundary_commit_latency", 64'(n), 64'd512);

        // All channels full, then asynchronous reset mid-period.
        repeat (10) @(negedge clock);
        cmd = '1;
        e = '0;
        for (int k = 0; k < NUM_CH; k++) e[k] = 10'd510;
        sb_q.push_back(e);
        bus_a.led_commands = cmd;
        bus_a.cmd_valid = 1'b1;
        @(negedge clock);
        bus_a.cmd_valid = 1'b0;
        wait_fs(600, n);
        repeat (200) @(negedge clock);
        check("all_on_mid", 64'(pins_a), 64'h3FFFF);
        #2 reset = 1'b0;
        #1;
        check("async_pins", 64'(pins_a), 64'd0);
        check("async_ready", 64'(bus_a.cmd_ready), 64'd1);
        check("async_fs", 64'(fs_a), 64'd0);

        // Release with a command already waiting: first commit must take one full period.
        @(negedge clock);
        reset = 1'b1;
        cmd = '0;
        cmd[9*DUTY_W +: DUTY_W] = 8'h03;
        e = '0; e[9] = 10'd6;
        sb_q.push_back(e);
        bus_a.led_commands = cmd;
        bus_a.cmd_valid = 1'b1;
        n = 0;
        bad_pins = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) bus_a.cmd_valid = 1'b0;
            if (!fs_a && pins_a != '0) bad_pins++;
        end while (!fs_a && n < 600);
        check("restart_full_period", 64'(n), 64'd512);
        check("post_reset_pins_zero", 64'(bad_pins), 64'd0);

        // PRESCALE=1 instance: ch5=1 gives one high clock per 256, one clock after the wrap.
        bus_b.led_commands = '0;
        bus_b.led_commands[5*DUTY_W +: DUTY_W] = 8'd1;
        bus_b.cmd_valid = 1'b1;
        @(negedge clock);
        bus_b.cmd_valid = 1'b0;
        n = 0;
        while (!fs_b && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("b_fs_within_bound", 64'(fs_b), 64'd1);
        b_high = 0; b_first = -1; b_second = -1; b_other = 0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clock);
            if (pins_b[5]) begin
                b_high++;
                if (b_first < 0) b_first = i;
                else if (b_second < 0) b_second = i;
            end
            if ((pins_b & ~(18'd1 << 5)) != '0) b_other++;
        end
        check("b_pin5_high_count", 64'(b_high), 64'd2);
        check("b_pin5_first_rise", 64'(b_first), 64'd1);
        check("b_pin5_second_rise", 64'(b_second), 64'd257);
        check("b_other_pins_zero", 64'(b_other), 64'd0);

        repeat (10) @(negedge clock);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("frames_measured", 64'(frames_checked), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
